mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for the EX stage. It sits beside the ALU and takes the same A/B register operands.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Downstream, the ALU result path and MFHI/MFLO read HI/LO directly. The pipeline controller stalls on busy.

---
 rtl/mul_div_pkg.sv | 25 ++
 rtl/mul_div_step.sv | 36 +++
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the per-iteration step mode.
package mul_div_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } md_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add for
// multiply, restoring shift-subtract for divide. Purely combinational.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  step_mode_e           mode_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: {partial product, multiplier}, consume multiplier LSB and shift right.
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opd_i};
        // Divide: {remainder, dividend/quotient}, shift left and trial-subtract.
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        ge     = (rem_sh >= {1'b0, opd_i});
        diff   = rem_sh[WIDTH-1:0] - opd_i;
        acc_o  = '0;
        if (mode_i == STEP_MUL) begin
            acc_o = acc_i[0] ? {sum, acc_i[WIDTH-1:1]}
                             : {1'b0, acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1:1]};
        end else begin
            acc_o = ge ? {diff, acc_i[WIDTH-2:0], 1'b1}
                       : {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Works on magnitudes for
// WIDTH iterations, then applies the result signs in a single fixup cycle.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   opd_q, opd_d, a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    step_mode_e         mode_q, mode_d;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d, done_q, done_d;
    logic               sgn_op, sa, sb;

    function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_dw(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .opd_i  (opd_q),
        .acc_o  (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        a_d       = a_q;
        mode_d    = mode_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        sgn_op    = (op == MD_MULT) || (op == MD_DIV);
        sa        = sgn_op & A[WIDTH-1];
        sb        = sgn_op & B[WIDTH-1];
        prod      = neg_dw(neg_res_q, acc_q);
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        state_d   = ST_CALC;
                        cnt_d     = '0;
                        acc_d     = {{WIDTH{1'b0}}, neg_w(sa, A)};
                        opd_d     = neg_w(sb, B);
                        a_d       = A;
                        mode_d    = op[1] ? STEP_DIV : STEP_MUL;
                        neg_res_d = sa ^ sb;
                        neg_rem_d = sa;
                        div0_d    = (B == '0);
                    end else if (op == MD_MTHI) begin
                        hi_d = A;
                    end else if (op == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (mode_q == STEP_MUL) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (div0_q) begin
                        // Divide by zero returns the dividend untouched and an all-ones quotient.
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = neg_w(neg_rem_q, acc_q[2*WIDTH-1:WIDTH]);
                        lo_d = neg_w(neg_res_q, acc_q[WIDTH-1:0]);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Operand/accumulator state is only meaningful after a load, so it carries no reset.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        opd_q     <= opd_d;
        a_q       <= a_d;
        mode_q    <= mode_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        div0_q    <= div0_d;
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected {hi,lo} queued at issue time,
// popped and compared on every done pulse.
module tb_mul_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n, start, flush;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [63:0] sb_q[$];

    mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("result", {hi, lo}, sb_q.pop_front());
        end
    end

    // Called on a falling edge; start is held for exactly one rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_timeout", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int          bc, n, d0;
        logic [63:0] hs;
        logic [31:0] ra, rb;
        logic [2:0]  ro;

        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 3'b0;
        A       = '0;
        B       = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // MTHI / MTLO write immediately, no busy and no done
        d0 = done_cnt;
        issue(OP_MTHI, 32'h1234_5678, 32'h0, 0, 64'd0);
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(OP_MTLO, 32'hCAFE_F00D, 32'h0, 0, 64'd0);
        check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
        issue(3'b110, 32'hDEAD_BEEF, 32'h1, 0, 64'd0);
        check("reserved_nochange", {hi, lo}, 64'h1234_5678_CAFE_F00D);
        check("reserved_busy", 64'(busy), 64'd0);
        check("mt_no_done", 64'(done_cnt - d0), 64'd0);

        // MULTU max*max with latency / pulse width
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(bc), 64'd33);
        check("done_at_end", 64'(done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 1, 64'hFFFF_FFFF_FFFF_FFEB); wait_done();
        issue(OP_MULTU, 32'hFFFF_FFFD, 32'd7, 1, 64'h0000_0006_FFFF_FFEB); wait_done();
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD); wait_done();
        issue(OP_DIVU,  32'd100, 32'd7, 1, {32'd2, 32'd14}); wait_done();
        issue(OP_DIVU,  32'd100, 32'd0, 1, {32'd100, 32'hFFFF_FFFF}); wait_done();
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd0, 1, 64'hFFFF_FFF9_FFFF_FFFF); wait_done();
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000); wait_done();
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000); wait_done();
        issue(OP_DIV,   32'd7, 32'hFFFF_FFFE, 1, 64'h0000_0001_FFFF_FFFD); wait_done();

        // Flush mid-operation: no write, no done
        hs = {hi, lo};
        d0 = done_cnt;
        issue(OP_MULT, 32'd5, 32'd6, 0, 64'd0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hilo", {hi, lo}, hs);
        repeat (40) @(negedge clk);
        check("flush_no_done", 64'(done_cnt - d0), 64'd0);
        check("flush_hilo_late", {hi, lo}, hs);

        // Flush while idle drops a simultaneous start
        flush = 1'b1;
        issue(OP_MTHI, 32'h5555_AAAA, 32'h0, 0, 64'd0);
        flush = 1'b0;
        check("idle_flush_drop", {hi, lo}, hs);
        check("idle_flush_busy", 64'(busy), 64'd0);

        // Start while busy is ignored
        d0 = done_cnt;
        issue(OP_DIVU, 32'd100, 32'd7, 1, {32'd2, 32'd14});
        repeat (5) @(negedge clk);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'd0);
        wait_done();
        repeat (40) @(negedge clk);
        check("busy_start_one_done", 64'(done_cnt - d0), 64'd1);
        check("busy_start_hilo", {hi, lo}, {32'd2, 32'd14});

        // Start accepted in the done cycle
        issue(OP_DIVU, 32'd1000, 32'd3, 1, {32'd1, 32'd333});
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        issue(OP_MULTU, 32'd3, 32'd5, 1, 64'd15);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done();

        // Random operations against the model
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = 32'($urandom_range(1, 20));
            issue(ro, ra, rb, 1, model(ro, ra, rb));
            wait_done();
        end

        // Asynchronous reset mid-operation
        issue(OP_MULT, 32'h0000_1234, 32'h0000_5678, 0, 64'd0);
        repeat (19) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(OP_MULTU, 32'd12, 32'd12, 1, 64'd144);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
